// File: rtl/piezo_pkg.sv
// Shared note codes, keypad one-hot decode and FSM state type for the piezo melody sequencer.
package piezo_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_D    = 4'd2;
  localparam logic [3:0] NOTE_E    = 4'd3;
  localparam logic [3:0] NOTE_F    = 4'd4;
  localparam logic [3:0] NOTE_G    = 4'd5;
  localparam logic [3:0] NOTE_A    = 4'd6;
  localparam logic [3:0] NOTE_B    = 4'd7;
  localparam logic [3:0] NOTE_C2   = 4'd8;
  localparam logic [3:0] NOTE_END  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    NOTE = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Codes outside C..C' (rest, 9..14, END) decode to silence.
  function automatic logic [11:0] note_decode(input logic [3:0] code);
    logic [11:0] oh;
    oh = '0;
    if (code >= NOTE_C && code <= NOTE_C2) begin
      oh[code - NOTE_C] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/piezo_song_rom.sv
// Combinational song table: idx -> {code, beats}. Swap this file to change the melody.
module piezo_song_rom
  import piezo_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  output logic [3:0]       code,
  output logic [1:0]       beats
);

  always_comb begin
    code  = NOTE_END;
    beats = 2'd0;
    case (int'(idx))
      0:       begin code = NOTE_C;   beats = 2'd0; end
      1:       begin code = NOTE_C;   beats = 2'd0; end
      2:       begin code = NOTE_G;   beats = 2'd0; end
      3:       begin code = NOTE_G;   beats = 2'd0; end
      4:       begin code = NOTE_A;   beats = 2'd0; end
      5:       begin code = NOTE_A;   beats = 2'd0; end
      6:       begin code = NOTE_G;   beats = 2'd1; end
      default: begin code = NOTE_END; beats = 2'd0; end
    endcase
  end

endmodule

// File: rtl/piezo_melody_sequencer.sv
// Melody player with live keypad override. Define MELODY_LOOP_EN to repeat the song until stop
// instead of returning to IDLE with a done pulse.
module piezo_melody_sequencer
  import piezo_pkg::*;
#(
  parameter int BEAT_CYCLES = 250000,
  parameter int GAP_CYCLES  = 10000,
  parameter int SONG_LEN    = 8,
  parameter int IDX_W       = $clog2(SONG_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [11:0]      keypad_in,
  output logic [11:0]      note_out,
  output logic             playing,
  output logic [IDX_W-1:0] note_idx,
  output logic             done,
  output state_e           dbg_state
);

  localparam int DUR_W = $clog2(4 * BEAT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN - 1);

  // Handshake: start/stop are single-cycle pulses sampled on every edge, no ready side.
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [11:0]        note_q, note_d;
  logic               playing_q, playing_d;
  logic               done_q, done_d;

  logic [3:0]         rom_code;
  logic [1:0]         rom_beats;
  logic [CNT_W-1:0]   note_last;
  logic               end_song;
  logic               override;

  piezo_song_rom #(.IDX_W(IDX_W)) u_rom (
    .idx   (idx_q),
    .code  (rom_code),
    .beats (rom_beats)
  );

  always_comb begin
    case (rom_beats)
      2'd0:    note_last = CNT_W'(BEAT_CYCLES - 1);
      2'd1:    note_last = CNT_W'(2 * BEAT_CYCLES - 1);
      2'd2:    note_last = CNT_W'(3 * BEAT_CYCLES - 1);
      default: note_last = CNT_W'(4 * BEAT_CYCLES - 1);
    endcase
  end

  assign override = (keypad_in != 12'd0);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    end_song = 1'b0;

    if (stop) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (start && state_q == IDLE) begin
      state_d = LOAD;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (!override) begin
      // A held key freezes the whole melody timeline, so only advance when released.
      case (state_q)
        LOAD: begin
          if (rom_code == NOTE_END) begin
            end_song = 1'b1;
          end else begin
            state_d = NOTE;
            cnt_d   = '0;
          end
        end
        NOTE: begin
          if (cnt_q == note_last) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              end_song = 1'b1;
            end else begin
              state_d = LOAD;
              idx_d   = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase

      if (end_song) begin
        idx_d = '0;
        cnt_d = '0;
`ifdef MELODY_LOOP_EN
        state_d = LOAD;
`else
        state_d = IDLE;
        done_d  = 1'b1;
`endif
      end
    end

    // NOTE is only entered from LOAD with the index unchanged, so idx_q addresses the ROM here.
    playing_d = (state_d != IDLE);
    if (override) begin
      note_d = keypad_in;
    end else if (state_d == NOTE) begin
      note_d = note_decode(rom_code);
    end else begin
      note_d = 12'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      note_q    <= 12'd0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign note_out  = note_q;
  assign playing   = playing_q;
  assign note_idx  = idx_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_piezo_melody_sequencer.sv
// Self-checking bench for piezo_melody_sequencer against a schedule-based melody model.
module tb_piezo_melody_sequencer;
  import piezo_pkg::*;

  localparam int BEAT  = 10;
  localparam int GAPC  = 2;
  localparam int SLEN  = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [11:0]      keypad_in;
  logic [11:0]      note_out;
  logic             playing;
  logic [IDX_W-1:0] note_idx;
  logic             done;
  state_e           dbg_state;

  piezo_melody_sequencer #(
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAPC),
    .SONG_LEN    (SLEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .keypad_in (keypad_in),
    .note_out  (note_out),
    .playing   (playing),
    .note_idx  (note_idx),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: the whole song flattened into one entry per clock (LOAD, note cycles, gap cycles).
  logic [11:0] exp_q[$];
  int          exp_idx_q[$];
  int          song_code [SLEN] = '{1, 1, 5, 5, 6, 6, 5, 15};
  int          song_beats[SLEN] = '{0, 0, 0, 0, 0, 0, 1, 0};

  bit          m_playing;
  int          m_pos;
  logic [11:0] exp_note;
  int          exp_idx;
  bit          exp_done;

  int n_checks, n_fail;
  int h_c, h_g, h_a, h_k, done_cnt;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void build_schedule();
    logic [11:0] v;
    exp_q.delete();
    exp_idx_q.delete();
    for (int i = 0; i < SLEN; i++) begin
      exp_q.push_back(12'd0);
      exp_idx_q.push_back(i);
      if (song_code[i] == 15) break;
      v = 12'd0;
      if (song_code[i] >= 1 && song_code[i] <= 8) v = 12'd1 << (song_code[i] - 1);
      for (int k = 0; k < (song_beats[i] + 1) * BEAT; k++) begin
        exp_q.push_back(v);
        exp_idx_q.push_back(i);
      end
      for (int k = 0; k < GAPC; k++) begin
        exp_q.push_back(12'd0);
        exp_idx_q.push_back(i);
      end
    end
  endfunction

  // Predict the post-edge outputs from the inputs the DUT is about to sample.
  function automatic void model_step();
    exp_done = 1'b0;
    if (!rst) begin
      m_playing = 1'b0;
      m_pos     = 0;
    end else if (stop) begin
      m_playing = 1'b0;
      m_pos     = 0;
    end else if (start && !m_playing) begin
      m_playing = 1'b1;
      m_pos     = 0;
    end else if (keypad_in != 12'd0) begin
      m_pos = m_pos;
    end else if (m_playing) begin
      m_pos++;
      if (m_pos == exp_q.size()) begin
        m_pos = 0;
`ifndef MELODY_LOOP_EN
        m_playing = 1'b0;
        exp_done  = 1'b1;
`endif
      end
    end
    if (!rst) exp_note = 12'd0;
    else if (keypad_in != 12'd0) exp_note = keypad_in;
    else exp_note = m_playing ? exp_q[m_pos] : 12'd0;
    exp_idx = m_playing ? exp_idx_q[m_pos] : 0;
  endfunction

  // One clock: model prediction, edge, sample #1 later, compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("note_out", 32'(note_out), 32'(exp_note));
    check("playing", 32'(playing), 32'(m_playing));
    check("note_idx", 32'(note_idx), 32'(exp_idx));
    check("done", 32'(done), 32'(exp_done));
    check("state_vs_playing", 32'(dbg_state != IDLE), 32'(playing));
    case (note_out)
      12'h001: h_c++;
      12'h010: h_g++;
      12'h020: h_a++;
      12'h080: h_k++;
      default: ;
    endcase
    if (done) done_cnt++;
  endtask

  task automatic clear_hist();
    h_c = 0; h_g = 0; h_a = 0; h_k = 0; done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic run_until_done(input int max_cycles, output int n);
    n = 0;
    while (n < max_cycles) begin
      tick();
      n++;
      if (done) break;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int kp_hold;
    n_checks = 0;
    n_fail   = 0;
    m_playing = 1'b0;
    m_pos     = 0;
    exp_note  = 12'd0;
    exp_idx   = 0;
    exp_done  = 1'b0;
    clear_hist();
    build_schedule();
    check("model_len", 32'(exp_q.size()), 32'd102);

    // reset with keypad and start active
    rst = 1'b0; start = 1'b1; stop = 1'b0; keypad_in = 12'h004;
    repeat (3) tick();
    check("rst_note", 32'(note_out), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    rst = 1'b1; start = 1'b0; keypad_in = 12'd0;
    repeat (2) tick();

`ifndef MELODY_LOOP_EN
    // full song
    clear_hist();
    pulse_start();
    run_until_done(300, n);
    check("song_len", 32'(n), 32'd102);
    check("hist_c", 32'(h_c), 32'd20);
    check("hist_g", 32'(h_g), 32'd40);
    check("hist_a", 32'(h_a), 32'd20);
    check("end_playing", 32'(playing), 32'd0);
    repeat (3) tick();

    // stop during 5th cycle of the second note
    clear_hist();
    pulse_start();
    repeat (18) tick();
    pulse_stop();
    check("stop_note", 32'(note_out), 32'd0);
    check("stop_playing", 32'(playing), 32'd0);
    check("stop_idx", 32'(note_idx), 32'd0);
    repeat (5) tick();
    check("stop_no_done", 32'(done_cnt), 32'd0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 32'(playing), 32'd0);
    repeat (2) tick();

    // live override during note 0
    clear_hist();
    pulse_start();
    repeat (4) tick();
    keypad_in = 12'h080;
    repeat (7) tick();
    keypad_in = 12'd0;
    run_until_done(300, n);
    check("ovr_remaining", 32'(n), 32'd98);
    check("ovr_hist_k", 32'(h_k), 32'd7);
    check("ovr_hist_c", 32'(h_c), 32'd20);
    repeat (2) tick();
`else
    // looping playback over three passes
    clear_hist();
    pulse_start();
    repeat (306) tick();
    check("loop_no_done", 32'(done_cnt), 32'd0);
    check("loop_hist_c", 32'(h_c), 32'd60);
    check("loop_playing", 32'(playing), 32'd1);
    pulse_stop();
    repeat (2) tick();
`endif

    // keypad in IDLE
    keypad_in = 12'h002;
    tick();
    check("idle_kp_note", 32'(note_out), 32'h002);
    check("idle_kp_playing", 32'(playing), 32'd0);
    keypad_in = 12'd0;
    tick();
    check("idle_kp_release", 32'(note_out), 32'd0);

    // asynchronous reset mid-note
    pulse_start();
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("async_rst_note", 32'(note_out), 32'd0);
    check("async_rst_playing", 32'(playing), 32'd0);
    check("async_rst_idx", 32'(note_idx), 32'd0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // randomized start/stop/keypad traffic
    kp_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 99) < 3);
      stop  = ($urandom_range(0, 999) < 4);
      if (kp_hold > 0) begin
        kp_hold--;
      end else if ($urandom_range(0, 99) < 3) begin
        if ($urandom_range(0, 3) == 0) keypad_in = 12'($urandom_range(0, 4095));
        else keypad_in = 12'd1 << $urandom_range(0, 11);
        kp_hold = $urandom_range(1, 12);
      end else begin
        keypad_in = 12'd0;
      end
      tick();
    end
    start = 1'b0; stop = 1'b0; keypad_in = 12'd0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
